seg7_sequence_decoder: RTL

//  Reader side of the 7-segment display bus. Samples an active-low 7-segment pattern and filters
//  out glitches. Decodes the pattern back to a 4-bit hex digit. Tracks the counting sequence so it
//  can measure and check the modulus of the counter driving the display.

---
 rtl/seg7_sequence_decoder.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_sequence_decoder.sv
// Glitch-filtered active-low 7-segment reader: decodes hex digits and measures/locks the counter modulus.
// Optional watchdog on LOCKED under `SEG7_TIMEOUT_EN; accept latency STABLE_CYCLES+3 edges, no backpressure.
module seg7_sequence_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 60_000_000
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic [6:0] hex_in,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       illegal,
  output logic       seq_err,
  output logic [4:0] modulus,
  output logic       mod_valid,
  output logic       stall
);

  localparam int unsigned    SW       = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SW-1:0]  STAB_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [6:0]     BLANK    = 7'h7F;

  typedef enum logic [1:0] {ALIGN = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  // Returns {legal, digit}; legal is 0 for any pattern outside the table.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'b1000000: r = 5'h10;
      7'b1111001: r = 5'h11;
      7'b0100100: r = 5'h12;
      7'b0110000: r = 5'h13;
      7'b0011001: r = 5'h14;
      7'b0010010: r = 5'h15;
      7'b0000010: r = 5'h16;
      7'b1111000: r = 5'h17;
      7'b0000000: r = 5'h18;
      7'b0011000: r = 5'h19;
      7'b0001000: r = 5'h1A;
      7'b0000011: r = 5'h1B;
      7'b1000110: r = 5'h1C;
      7'b0100001: r = 5'h1D;
      7'b0000110: r = 5'h1E;
      7'b0001110: r = 5'h1F;
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  logic [6:0]    s1_q, s1_d, s2_q, s2_d, cand_q, cand_d, last_pat_q, last_pat_d;
  logic [SW-1:0] stab_q, stab_d;
  logic          armed_q, armed_d;
  state_t        state_q, state_d;
  logic [4:0]    step_q, step_d;
  logic [3:0]    digit_q, digit_d;
  logic [4:0]    modulus_q, modulus_d;
  logic          mod_valid_q, mod_valid_d;
  logic          digit_valid_q, digit_valid_d;
  logic          illegal_q, illegal_d;
  logic          seq_err_q, seq_err_d;
  logic          accept, lock_ok;
  logic [4:0]    dec, succ;

`ifdef SEG7_TIMEOUT_EN
  localparam int unsigned   WW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYCLES - 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          stall_q, stall_d;
`endif

  always_comb begin
    s1_d          = hex_in;
    s2_d          = s1_q;
    cand_d        = cand_q;
    stab_d        = stab_q;
    armed_d       = armed_q;
    last_pat_d    = last_pat_q;
    state_d       = state_q;
    step_d        = step_q;
    digit_d       = digit_q;
    modulus_d     = modulus_q;
    mod_valid_d   = mod_valid_q;
    digit_valid_d = 1'b0;
    illegal_d     = 1'b0;
    seq_err_d     = 1'b0;
    lock_ok       = 1'b0;
    dec           = decode(cand_q);
    succ          = {1'b0, digit_q} + 5'd1;

    // armed marks the first cycle at saturation, so a held pattern fires once.
    accept = (stab_q == STAB_MAX) && armed_q && (cand_q != last_pat_q);

    if (s2_q != cand_q) begin
      cand_d  = s2_q;
      stab_d  = '0;
      armed_d = 1'b1;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + SW'(1);
    end else begin
      armed_d = 1'b0;
    end

    if (accept) begin
      last_pat_d = cand_q;
      if (cand_q != BLANK) begin
        if (!dec[4]) begin
          illegal_d   = 1'b1;
          mod_valid_d = 1'b0;
          state_d     = ALIGN;
        end else begin
          digit_d       = dec[3:0];
          digit_valid_d = 1'b1;
          case (state_q)
            ALIGN: begin
              if (dec[3:0] == 4'd0) begin
                state_d = MEASURE;
                step_d  = 5'd1;
              end
            end
            MEASURE: begin
              if ({1'b0, dec[3:0]} == succ) begin
                step_d = step_q + 5'd1;
              end else if (dec[3:0] == 4'd0) begin
                modulus_d   = step_q;
                mod_valid_d = 1'b1;
                step_d      = 5'd1;
                state_d     = LOCKED;
              end else begin
                seq_err_d = 1'b1;
                state_d   = ALIGN;
              end
            end
            LOCKED: begin
              lock_ok = (({1'b0, dec[3:0]} == succ) && (succ < modulus_q)) ||
                        ((dec[3:0] == 4'd0) && ({1'b0, digit_q} == modulus_q - 5'd1));
              if (!lock_ok) begin
                seq_err_d   = 1'b1;
                mod_valid_d = 1'b0;
                if (dec[3:0] == 4'd0) begin
                  state_d = MEASURE;
                  step_d  = 5'd1;
                end else begin
                  state_d = ALIGN;
                end
              end
            end
            default: state_d = ALIGN;
          endcase
        end
      end
    end

`ifdef SEG7_TIMEOUT_EN
    stall_d = 1'b0;
    wd_d    = wd_q;
    if (accept) begin
      wd_d = '0;
    end else if (state_q == LOCKED) begin
      if (wd_q == WD_MAX) begin
        stall_d     = 1'b1;
        mod_valid_d = 1'b0;
        state_d     = ALIGN;
        wd_d        = '0;
      end else begin
        wd_d = wd_q + WW'(1);
      end
    end else begin
      wd_d = '0;
    end
`endif
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      s1_q          <= BLANK;
      s2_q          <= BLANK;
      cand_q        <= BLANK;
      last_pat_q    <= BLANK;
      stab_q        <= '0;
      armed_q       <= 1'b0;
      state_q       <= ALIGN;
      step_q        <= 5'd0;
      digit_q       <= 4'd0;
      modulus_q     <= 5'd0;
      mod_valid_q   <= 1'b0;
      digit_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      seq_err_q     <= 1'b0;
`ifdef SEG7_TIMEOUT_EN
      wd_q          <= '0;
      stall_q       <= 1'b0;
`endif
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      cand_q        <= cand_d;
      last_pat_q    <= last_pat_d;
      stab_q        <= stab_d;
      armed_q       <= armed_d;
      state_q       <= state_d;
      step_q        <= step_d;
      digit_q       <= digit_d;
      modulus_q     <= modulus_d;
      mod_valid_q   <= mod_valid_d;
      digit_valid_q <= digit_valid_d;
      illegal_q     <= illegal_d;
      seq_err_q     <= seq_err_d;
`ifdef SEG7_TIMEOUT_EN
      wd_q          <= wd_d;
      stall_q       <= stall_d;
`endif
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign illegal     = illegal_q;
  assign seq_err     = seq_err_q;
  assign modulus     = modulus_q;
  assign mod_valid   = mod_valid_q;
`ifdef SEG7_TIMEOUT_EN
  assign stall       = stall_q;
`else
  assign stall       = 1'b0;
`endif

endmodule
